// File: rtl/dec_job_scheduler.sv
// Job queue and sequencer for the Snappy decompression core: queues descriptors, launches one job at a time, returns tagged completions.
// Optional run-time counter is built when DEC_SCHED_PERF_EN is defined; otherwise cmp_cycles is tied to 0.
module dec_job_scheduler #(
  parameter int ADDR_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 4,
  parameter int ID_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [ADDR_WIDTH-1:0]          job_src_addr,
  input  logic [ADDR_WIDTH-1:0]          job_des_addr,
  input  logic [31:0]                    job_comp_len,
  input  logic [31:0]                    job_decomp_len,
  input  logic [ID_WIDTH-1:0]            job_id,
  output logic                           core_start,
  output logic [ADDR_WIDTH-1:0]          core_src_addr,
  output logic [ADDR_WIDTH-1:0]          core_des_addr,
  output logic [31:0]                    core_comp_len,
  output logic [31:0]                    core_decomp_len,
  input  logic                           core_ready,
  input  logic                           core_done,
  output logic                           cmp_valid,
  input  logic                           cmp_ready,
  output logic [ID_WIDTH-1:0]            cmp_id,
  output logic [1:0]                     cmp_status,
  output logic [31:0]                    cmp_cycles,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARM, S_RUN, S_REPORT} state_e;

  state_e                state_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop, head_zero;

  logic [ADDR_WIDTH-1:0] src_mem    [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] des_mem    [QUEUE_DEPTH];
  logic [31:0]           comp_mem   [QUEUE_DEPTH];
  logic [31:0]           decomp_mem [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]   id_mem     [QUEUE_DEPTH];

  logic                  core_start_q;
  logic [ADDR_WIDTH-1:0] core_src_q, core_des_q;
  logic [31:0]           core_comp_q, core_decomp_q;
  logic [ID_WIDTH-1:0]   run_id_q;
  logic                  cmp_valid_q;
  logic [ID_WIDTH-1:0]   cmp_id_q;
  logic [1:0]            cmp_status_q;

  always_comb begin
    job_ready = count_q < CW'(QUEUE_DEPTH);
    push      = job_valid && job_ready;
    head_zero = (comp_mem[rd_ptr_q] == 32'd0) || (decomp_mem[rd_ptr_q] == 32'd0);
    pop       = (state_q == S_IDLE) && (count_q != '0) && (head_zero || core_ready);
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr_q]    <= job_src_addr;
      des_mem[wr_ptr_q]    <= job_des_addr;
      comp_mem[wr_ptr_q]   <= job_comp_len;
      decomp_mem[wr_ptr_q] <= job_decomp_len;
      id_mem[wr_ptr_q]     <= job_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef DEC_SCHED_PERF_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] cmp_cycles_q;

  // Zero on the launch edge so the LAUNCH cycle reads 0; saturates at all-ones.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (pop && !head_zero)
      run_cnt_d = '0;
    else if ((state_q == S_LAUNCH || state_q == S_ARM || state_q == S_RUN) && run_cnt_q != '1)
      run_cnt_d = run_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q    <= '0;
      cmp_cycles_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      if (pop && head_zero)
        cmp_cycles_q <= '0;
      else if (state_q == S_RUN && core_done)
        cmp_cycles_q <= run_cnt_q;
    end
  end

  assign cmp_cycles = cmp_cycles_q;
`else
  assign cmp_cycles = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      core_start_q  <= 1'b0;
      core_src_q    <= '0;
      core_des_q    <= '0;
      core_comp_q   <= '0;
      core_decomp_q <= '0;
      run_id_q      <= '0;
      cmp_valid_q   <= 1'b0;
      cmp_id_q      <= '0;
      cmp_status_q  <= '0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop && head_zero) begin
            cmp_valid_q  <= 1'b1;
            cmp_id_q     <= id_mem[rd_ptr_q];
            cmp_status_q <= 2'd1;
            state_q      <= S_REPORT;
          end else if (pop) begin
            core_src_q    <= src_mem[rd_ptr_q];
            core_des_q    <= des_mem[rd_ptr_q];
            core_comp_q   <= comp_mem[rd_ptr_q];
            core_decomp_q <= decomp_mem[rd_ptr_q];
            run_id_q      <= id_mem[rd_ptr_q];
            core_start_q  <= 1'b1;
            state_q       <= S_LAUNCH;
          end
        end
        S_LAUNCH: state_q <= S_ARM;
        // A done level still high from the previous job must drop before this job can finish.
        S_ARM: if (!core_done) state_q <= S_RUN;
        S_RUN: begin
          if (core_done) begin
            cmp_valid_q  <= 1'b1;
            cmp_id_q     <= run_id_q;
            cmp_status_q <= 2'd0;
            state_q      <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (cmp_ready) begin
            cmp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start      = core_start_q;
  assign core_src_addr   = core_src_q;
  assign core_des_addr   = core_des_q;
  assign core_comp_len   = core_comp_q;
  assign core_decomp_len = core_decomp_q;
  assign cmp_valid       = cmp_valid_q;
  assign cmp_id          = cmp_id_q;
  assign cmp_status      = cmp_status_q;
  assign busy            = (state_q != S_IDLE) || (count_q != '0);
  assign queue_count     = count_q;

endmodule

// File: tb/tb_dec_job_scheduler.sv
// Directed self-checking bench for dec_job_scheduler: latency, queue full, stale done, zero-length, backpressure, reset.
module tb_dec_job_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready;
  logic [63:0] job_src_addr, job_des_addr;
  logic [31:0] job_comp_len, job_decomp_len;
  logic [7:0]  job_id;
  logic        core_start;
  logic [63:0] core_src_addr, core_des_addr;
  logic [31:0] core_comp_len, core_decomp_len;
  logic        core_ready, core_done;
  logic        cmp_valid, cmp_ready;
  logic [7:0]  cmp_id;
  logic [1:0]  cmp_status;
  logic [31:0] cmp_cycles;
  logic        busy;
  logic [2:0]  queue_count;

  int checks = 0;
  int errors = 0;

`ifdef DEC_SCHED_PERF_EN
  localparam logic [31:0] EXP_CYC = 32'd20;
`else
  localparam logic [31:0] EXP_CYC = 32'd0;
`endif

  dec_job_scheduler #(.ADDR_WIDTH(64), .QUEUE_DEPTH(4), .ID_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src_addr(job_src_addr), .job_des_addr(job_des_addr),
    .job_comp_len(job_comp_len), .job_decomp_len(job_decomp_len), .job_id(job_id),
    .core_start(core_start), .core_src_addr(core_src_addr), .core_des_addr(core_des_addr),
    .core_comp_len(core_comp_len), .core_decomp_len(core_decomp_len),
    .core_ready(core_ready), .core_done(core_done),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
    .cmp_status(cmp_status), .cmp_cycles(cmp_cycles),
    .busy(busy), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input logic [63:0] s, input logic [63:0] d,
                         input logic [31:0] c, input logic [31:0] dl, input logic [7:0] id);
    job_src_addr = s; job_des_addr = d; job_comp_len = c; job_decomp_len = dl; job_id = id;
  endtask

  task automatic push(input logic [63:0] s, input logic [63:0] d,
                      input logic [31:0] c, input logic [31:0] dl, input logic [7:0] id);
    set_job(s, d, c, dl, id);
    job_valid = 1'b1;
    step;
    job_valid = 1'b0;
  endtask

  task automatic wait_start(input logic [7:0] tag);
    for (int i = 0; i < 10 && core_start !== 1'b1; i++) step;
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL start_timeout job %0d: core_start=%b required 1", tag, core_start);
    end
  endtask

  // Drives done low then high from ARM/RUN, then checks and accepts the record.
  task automatic finish_job(input logic [7:0] exp_id);
    core_done = 1'b0;
    step; step;
    core_done = 1'b1;
    for (int i = 0; i < 20 && cmp_valid !== 1'b1; i++) step;
    checks++;
    if (cmp_valid !== 1'b1 || cmp_id !== exp_id || cmp_status !== 2'd0) begin
      errors++;
      $display("FAIL completion: valid=%b id=%0d status=%0d required 1/%0d/0",
               cmp_valid, cmp_id, cmp_status, exp_id);
    end
    cmp_ready = 1'b1;
    step;
    cmp_ready = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] exp_id);
    wait_start(exp_id);
    finish_job(exp_id);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step; step;
    checks++;
    if ({job_ready, core_start, cmp_valid, busy, queue_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: ready/start/valid/busy/count=%b%b%b%b/%0d required 1000/0",
               job_ready, core_start, cmp_valid, busy, queue_count);
    end
    checks++;
    if ({core_src_addr, core_des_addr, core_comp_len, core_decomp_len} !== 192'd0) begin
      errors++;
      $display("FAIL reset_core_data: src=%h des=%h required 0", core_src_addr, core_des_addr);
    end
    checks++;
    if ({cmp_id, cmp_status, cmp_cycles} !== 42'd0) begin
      errors++;
      $display("FAIL reset_cmp: id=%0d status=%0d cycles=%0d required 0", cmp_id, cmp_status, cmp_cycles);
    end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single;
    logic bad = 1'b0;
    push(64'h1000, 64'h8000, 32'd64, 32'd256, 8'd5);
    checks++;
    if (queue_count !== 3'd1 || core_start !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: count=%0d start=%b required 1/0", queue_count, core_start);
    end
    step;
    checks++;
    if (core_start !== 1'b1 || core_src_addr !== 64'h1000 || core_des_addr !== 64'h8000 ||
        core_comp_len !== 32'd64 || core_decomp_len !== 32'd256) begin
      errors++;
      $display("FAIL single_launch: start=%b src=%h des=%h comp=%0d decomp=%0d required 1/1000/8000/64/256",
               core_start, core_src_addr, core_des_addr, core_comp_len, core_decomp_len);
    end
    for (int i = 1; i <= 20; i++) begin
      step;
      if (core_start !== 1'b0 || cmp_valid !== 1'b0 || core_src_addr !== 64'h1000 ||
          core_des_addr !== 64'h8000 || core_comp_len !== 32'd64 || core_decomp_len !== 32'd256) bad = 1'b1;
    end
    core_done = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: disturbance=%b required 0", bad);
    end
    step;
    checks++;
    if (cmp_valid !== 1'b1 || cmp_id !== 8'd5 || cmp_status !== 2'd0 || cmp_cycles !== EXP_CYC) begin
      errors++;
      $display("FAIL single_cmp: valid=%b id=%0d status=%0d cycles=%0d required 1/5/0/%0d",
               cmp_valid, cmp_id, cmp_status, cmp_cycles, EXP_CYC);
    end
    cmp_ready = 1'b1;
    step;
    cmp_ready = 1'b0;
    core_done = 1'b0;
    checks++;
    if (cmp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after: valid=%b busy=%b required 0/0", cmp_valid, busy);
    end
  endtask

  task automatic test_full;
    core_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(64'h100 * i, 64'h200 * i, 32'd1, 32'd1, 8'(10 + i));
    checks++;
    if (job_ready !== 1'b0 || queue_count !== 3'd4) begin
      errors++;
      $display("FAIL full_ready: ready=%b count=%0d required 0/4", job_ready, queue_count);
    end
    set_job(64'h500, 64'h600, 32'd1, 32'd1, 8'd14);
    job_valid = 1'b1;
    step; step;
    checks++;
    if (queue_count !== 3'd4 || core_start !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: count=%0d start=%b required 4/0", queue_count, core_start);
    end
    core_ready = 1'b1;
    step;
    checks++;
    if (core_start !== 1'b1 || job_ready !== 1'b1 || queue_count !== 3'd3 || core_src_addr !== 64'h0) begin
      errors++;
      $display("FAIL full_pop: start=%b ready=%b count=%0d src=%h required 1/1/3/0",
               core_start, job_ready, queue_count, core_src_addr);
    end
    step;
    job_valid = 1'b0;
    checks++;
    if (queue_count !== 3'd4) begin
      errors++;
      $display("FAIL full_fifth: count=%0d required 4", queue_count);
    end
    finish_job(8'd10);
    for (int i = 11; i <= 14; i++) run_one(8'(i));
    checks++;
    if (queue_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: count=%0d busy=%b required 0/0", queue_count, busy);
    end
  endtask

  task automatic test_stale_done;
    logic early = 1'b0;
    core_done = 1'b1;
    push(64'h2000, 64'h3000, 32'd8, 32'd8, 8'd20);
    wait_start(8'd20);
    for (int i = 0; i < 6; i++) begin
      step;
      if (cmp_valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL stale_done: early completion=%b required 0", early);
    end
    finish_job(8'd20);
  endtask

  task automatic test_zero_len;
    logic started = 1'b0;
    push(64'h4000, 64'h5000, 32'd0, 32'd16, 8'd9);
    if (core_start !== 1'b0) started = 1'b1;
    checks++;
    if (cmp_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_early: valid=%b required 0", cmp_valid);
    end
    step;
    if (core_start !== 1'b0) started = 1'b1;
    checks++;
    if (cmp_valid !== 1'b1 || cmp_id !== 8'd9 || cmp_status !== 2'd1 || cmp_cycles !== 32'd0 || started !== 1'b0) begin
      errors++;
      $display("FAIL zero_cmp: valid=%b id=%0d status=%0d cycles=%0d started=%b required 1/9/1/0/0",
               cmp_valid, cmp_id, cmp_status, cmp_cycles, started);
    end
    cmp_ready = 1'b1;
    step;
    push(64'h0, 64'h0, 32'd5, 32'd0, 8'd30);
    push(64'h0, 64'h0, 32'd0, 32'd0, 8'd31);
    checks++;
    if (cmp_valid !== 1'b1 || cmp_id !== 8'd30 || cmp_status !== 2'd1) begin
      errors++;
      $display("FAIL zero_b2b_first: valid=%b id=%0d status=%0d required 1/30/1", cmp_valid, cmp_id, cmp_status);
    end
    step; step;
    checks++;
    if (cmp_valid !== 1'b1 || cmp_id !== 8'd31 || cmp_status !== 2'd1 || core_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_b2b_second: valid=%b id=%0d status=%0d start=%b required 1/31/1/0",
               cmp_valid, cmp_id, cmp_status, core_start);
    end
    step;
    cmp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic moved = 1'b0;
    push(64'h7000, 64'h7100, 32'd4, 32'd4, 8'd40);
    push(64'h7200, 64'h7300, 32'd4, 32'd4, 8'd41);
    wait_start(8'd40);
    core_done = 1'b0;
    step; step;
    core_done = 1'b1;
    for (int i = 0; i < 20 && cmp_valid !== 1'b1; i++) step;
    for (int i = 0; i < 10; i++) begin
      if (cmp_valid !== 1'b1 || cmp_id !== 8'd40 || cmp_status !== 2'd0 || core_start !== 1'b0) moved = 1'b1;
      step;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: record disturbed=%b required 0 (id=%0d)", moved, cmp_id);
    end
    cmp_ready = 1'b1;
    step;
    cmp_ready = 1'b0;
    checks++;
    if (core_start !== 1'b0 || cmp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_h1: start=%b valid=%b required 0/0", core_start, cmp_valid);
    end
    step;
    checks++;
    if (core_start !== 1'b1 || core_src_addr !== 64'h7200) begin
      errors++;
      $display("FAIL bp_h2: start=%b src=%h required 1/7200", core_start, core_src_addr);
    end
    finish_job(8'd41);
  endtask

  task automatic test_reset_mid;
    logic leak = 1'b0;
    push(64'hA000, 64'hB000, 32'd3, 32'd3, 8'd50);
    push(64'hA100, 64'hB100, 32'd3, 32'd3, 8'd51);
    push(64'hA200, 64'hB200, 32'd3, 32'd3, 8'd52);
    core_done = 1'b0;
    step;
    checks++;
    if (queue_count !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_prereset: count=%0d busy=%b required 2/1", queue_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({job_ready, core_start, cmp_valid, busy, queue_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0} ||
        core_src_addr !== 64'd0 || core_comp_len !== 32'd0 || cmp_id !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: ready/start/valid/busy=%b%b%b%b count=%0d src=%h id=%0d required 1000/0/0/0",
               job_ready, core_start, cmp_valid, busy, queue_count, core_src_addr, cmp_id);
    end
    step; step;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step;
      if (cmp_valid !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0) leak = 1'b1;
    end
    checks++;
    if (leak !== 1'b0 || queue_count !== 3'd0) begin
      errors++;
      $display("FAIL mid_after: activity=%b count=%0d required 0/0", leak, queue_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; core_ready = 1'b1; core_done = 1'b0; cmp_ready = 1'b0;
    set_job(64'd0, 64'd0, 32'd0, 32'd0, 8'd0);
    test_reset;
    test_single;
    test_full;
    test_stale_done;
    test_zero_len;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dec_job_scheduler.md
# dec_job_scheduler

Job queue and sequencer for the Snappy decompression core, which runs one job at a time. Software-side logic pushes job descriptors (source/destination address, compressed/decompressed length, tag) into a small on-chip queue. The scheduler launches each job on the core with a one-cycle start pulse, holds the job parameters stable while the core runs, and detects completion. It then returns a tagged completion record through a valid/ready port.

## Interface
- ADDR_WIDTH, 64, width of source/destination addresses
- QUEUE_DEPTH, 4, descriptor queue entries; power of two, ≥2
- ID_WIDTH, 8, job tag width

- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- job_valid  in  1  descriptor offered
- job_ready  out  1  queue not full
- job_src_addr / job_des_addr  in  ADDR_WIDTH each  host read/write base addresses
- job_comp_len / job_decomp_len  in  32 each  byte lengths
- job_id  in  ID_WIDTH  tag returned on completion
- core_start  out  1  one-cycle launch pulse to core
- core_src_addr / core_des_addr  out  ADDR_WIDTH each  held from launch to completion
- core_comp_len / core_decomp_len  out  32 each  held from launch to completion
- core_ready  in  1  core can accept start
- core_done  in  1  level; core job finished (decompressor AND io control)
- cmp_valid  out  1  completion record valid
- cmp_ready  in  1  completion consumer ready
- cmp_id  out  ID_WIDTH  tag of completed job
- cmp_status  out  2  0=OK, 1=skipped (zero length), 2–3 reserved
- cmp_cycles  out  32  core run time (0 when DEC_SCHED_PERF_EN undefined)
- busy  out  1  FSM not IDLE or queue not empty
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

## Operation
- Queue: circular FIFO with registered read/write pointers and count.
  - Push when job_valid && job_ready; job_ready = count < QUEUE_DEPTH.
  - Push and pop in the same cycle leave count unchanged; a push on a full queue is impossible.
  - Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, LAUNCH, ARM, RUN, REPORT.
- IDLE, count > 0:
  - Head has comp_len == 0 or decomp_len == 0: pop, load tag, status=1, cycles=0, go to REPORT. The core is not touched.
  - Otherwise, if core_ready: pop, latch the head into the core_* registers, go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: core_start=1 for exactly this cycle, then go to ARM.
- ARM: wait until core_done is sampled 0. This discards a stale done level left by the previous job. Then go to RUN.
- RUN: when core_done is sampled 1, set status=0 and go to REPORT.
- REPORT: hold cmp_valid=1 and the record stable until cmp_valid && cmp_ready, then go to IDLE.
- core_* outputs change only on the IDLE→LAUNCH transition.
- Queue pushes are accepted in every state.

## Timing
- Reset values (async assert, sync deassert by the system):
  - FSM=IDLE, queue empty, job_ready=1.
  - core_start=0, core_* data=0.
  - cmp_valid=0, cmp_id=0, cmp_status=0, cmp_cycles=0.
  - busy=0, queue_count=0.
- Reset mid-job: discard all queued and running jobs. The core must be reset by the same rst_n.
- Latency, with the core ready:
  - Push accepted at cycle t; queue_count updates at t+1.
  - IDLE pops at t+1; core_start=1 at t+2.
- Completion: core_done first seen high in RUN at cycle d; cmp_valid=1 from d+1.
- Handshake at cycle h; next launch core_start no earlier than h+2.
- Back-to-back zero-length jobs: one record per two cycles, minimum.
- cmp_cycles counts cycles from the LAUNCH cycle (value 0) to the done-sampling cycle d, saturating at 2^32−1.

## Configuration
- DEC_SCHED_PERF_EN defined: 32-bit saturating run counter is built; cmp_cycles reports it.
- DEC_SCHED_PERF_EN undefined: no counter is synthesized; cmp_cycles is tied to 0.

## Test plan
- Single job (src=0x1000, des=0x8000, comp=64, decomp=256, id=5), core_done rises 20 cycles after start:
  - exactly one core_start pulse, two cycles after the push;
  - core_* held until completion;
  - cmp_id=5, status=0, cmp_cycles=20 with PERF_EN.
- Push 5 jobs back-to-back, QUEUE_DEPTH=4, core stalled:
  - job_ready drops after 4 accepts;
  - the 5th is accepted when the first is popped;
  - completions arrive in push order.
- core_done stuck high from the previous job:
  - no completion until done is seen low and then high again.
- Job with comp_len=0, id=9:
  - no core_start;
  - cmp_status=1, cmp_id=9 within 2 cycles of reaching the queue head.
- cmp_ready held low for 10 cycles during REPORT:
  - record stable;
  - no new core_start until the handshake.
- rst_n asserted while in RUN with 2 jobs queued:
  - all outputs take reset values immediately;
  - queue_count=0;
  - no completion emitted after release.
